// File: rtl/filter_chan_sched.sv
// filter_chan_sched: round-robin scheduler sharing one IIR filter core between
// NCH sample channels. Each channel holds one pending sample (newest wins).
// Samples go to the core one at a time, and each result is tagged with its
// channel before it is forwarded downstream.
//
// Optional build macro FILT_SCHED_WDOG_EN adds a WAIT watchdog. When it fires,
// the outstanding sample is dropped after WDOG_CYC WAIT cycles without a result.
//
// Handshake: every *_valid is a 1-cycle strobe. Its data and channel are
// meaningful only in that cycle. There is no backpressure on any side. The
// core must accept core_in_valid at once and answer with exactly one
// core_out_valid while busy is high in WAIT. core_out_valid outside WAIT is
// ignored.
module filter_chan_sched #(
  parameter int IO_B     = 16,
  parameter int NCH      = 4,
  parameter int WDOG_CYC = 64,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCH*IO_B-1:0] ch_data,
  input  logic [NCH-1:0]      ch_valid,
  output logic [NCH-1:0]      ch_overrun,
  output logic [IO_B-1:0]     core_in_data,
  output logic                core_in_valid,
  output logic [CH_W-1:0]     core_chan,
  input  logic [IO_B-1:0]     core_out_data,
  input  logic                core_out_valid,
  output logic [IO_B-1:0]     out_data,
  output logic [CH_W-1:0]     out_chan,
  output logic                out_valid,
  output logic                busy,
  output logic                wdog_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [NCH-1:0]    pend_q;
  logic [NCH-1:0]    pend_d;
  logic [NCH-1:0]    ovr_d;
  logic [IO_B-1:0]   pdata_q [NCH];
  logic [CH_W-1:0]   last_q;
  logic [CH_W-1:0]   g_q;
  logic [CH_W-1:0]   grant;
  logic              any_pend;
  logic              issue;
  logic              wd_expire;

  assign issue = (state_q == S_ISSUE);

  // Round-robin search: the first pending channel after the last grant, wrapping.
  always_comb begin
    logic [CH_W-1:0] idx;
    grant    = '0;
    any_pend = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CH_W'((int'(last_q) + k) % NCH);
      if (!any_pend && pend_q[idx]) begin
        any_pend = 1'b1;
        grant    = idx;
      end
    end
  end

  // Next pending set and overrun flags. A capture into the channel being issued
  // this cycle re-arms it without counting as an overrun.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = '0;
    if (issue) begin
      pend_d[g_q] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(issue && (g_q == CH_W'(i)))) begin
          ovr_d[i] = 1'b1;
        end
      end
    end
  end

  // Per-channel sample holding registers and the pending/overrun flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      ch_overrun <= '0;
      for (int i = 0; i < NCH; i++) begin
        pdata_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      ch_overrun <= ovr_d;
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i]) begin
          pdata_q[i] <= ch_data[i*IO_B +: IO_B];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> ISSUE -> WAIT -> IDLE. A transaction ends on a result or on a watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_pend) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_out_valid || wd_expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant and last-grant tracking, plus the registered, channel-tagged result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q       <= '0;
      last_q    <= CH_W'(NCH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state_q == S_IDLE && any_pend) begin
        g_q <= grant;
      end
      if (state_q == S_WAIT && (core_out_valid || wd_expire)) begin
        last_q <= g_q;
      end
      if (state_q == S_WAIT && core_out_valid) begin
        out_valid <= 1'b1;
        out_data  <= core_out_data;
        out_chan  <= g_q;
      end
    end
  end

`ifdef FILT_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q;

  // The counter holds the number of WAIT cycles already completed. Expiry is
  // therefore the WDOG_CYC-th WAIT cycle, provided no result arrives in it.
  assign wd_expire = (state_q == S_WAIT) && !core_out_valid &&
                     (wd_cnt_q == WD_W'(WDOG_CYC - 1));
  assign wdog_err  = wd_expire;

  // Watchdog counter: cleared while entering WAIT, incremented on every WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  // Without the watchdog, WAIT holds until the core answers. WDOG_CYC has no effect in this build.
  logic unused_wdog_cyc;
  assign unused_wdog_cyc = ^WDOG_CYC;
  assign wd_expire       = 1'b0;
  assign wdog_err        = 1'b0;
`endif

  assign core_in_valid = issue;
  assign core_in_data  = issue ? pdata_q[g_q] : '0;
  assign core_chan     = g_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_chan_sched.sv
// tb_filter_chan_sched: a randomized bench with directed scenarios for filter_chan_sched.
// A core model answers issued samples after a random latency and sometimes
// strobes spuriously. A transaction-level reference model pushes the expected
// issues, results and overruns into queues. A monitor pops those entries and
// compares them with what the DUT presents.
`timescale 1ns/1ps
module tb_filter_chan_sched;
  localparam int IO_B     = 16;
  localparam int NCH      = 4;
  localparam int WDOG_CYC = 64;
  localparam int CH_W     = $clog2(NCH);

  typedef struct packed {
    logic [31:0]     cyc;
    logic [7:0]      chan;
    logic [IO_B-1:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NCH*IO_B-1:0] ch_data;
  logic [NCH-1:0]      ch_valid;
  logic [NCH-1:0]      ch_overrun;
  logic [IO_B-1:0]     core_in_data;
  logic                core_in_valid;
  logic [CH_W-1:0]     core_chan;
  logic [IO_B-1:0]     core_out_data;
  logic                core_out_valid;
  logic [IO_B-1:0]     out_data;
  logic [CH_W-1:0]     out_chan;
  logic                out_valid;
  logic                busy;
  logic                wdog_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Core model controls, set by the main sequence.
  int lat_min   = 1;
  int lat_max   = 12;
  bit spur_en   = 1'b0;
  bit no_resp   = 1'b0;
  int spur_tok  = 0;
  bit end_req   = 1'b0;
  bit end_done  = 1'b0;

  // Reference model state.
  bit              m_pend  [NCH];
  logic [IO_B-1:0] m_pdata [NCH];
  int              m_last;
  int              m_g;
  int              m_issue_cyc;
  bit              m_issuing;
  bit              m_waiting;
  exp_t            exp_issue_q[$];
  exp_t            exp_out_q[$];
  exp_t            exp_ovr_q[$];

  filter_chan_sched #(.IO_B(IO_B), .NCH(NCH), .WDOG_CYC(WDOG_CYC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ch_data        (ch_data),
    .ch_valid       (ch_valid),
    .ch_overrun     (ch_overrun),
    .core_in_data   (core_in_data),
    .core_in_valid  (core_in_valid),
    .core_chan      (core_chan),
    .core_out_data  (core_out_data),
    .core_out_valid (core_out_valid),
    .out_data       (out_data),
    .out_chan       (out_chan),
    .out_valid      (out_valid),
    .busy           (busy),
    .wdog_err       (wdog_err)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic exp_t mk(input int c, input int ch, input logic [IO_B-1:0] d);
    exp_t e;
    e.cyc  = 32'(c);
    e.chan = 8'(ch);
    e.data = d;
    return e;
  endfunction

  function automatic logic [NCH*IO_B-1:0] rand_data();
    logic [NCH*IO_B-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*IO_B +: IO_B] = IO_B'($urandom);
    return v;
  endfunction

  task automatic cmp_exp(input string name, input exp_t e, input int chan, input logic [IO_B-1:0] data);
    checks++;
    if (int'(e.cyc) != cyc || int'(e.chan) != chan || e.data != data) begin
      errors++;
      $display("FAIL %s at cyc %0d: got chan=%0d data=%h, expected cyc=%0d chan=%0d data=%h",
               name, cyc, chan, data, e.cyc, e.chan, e.data);
    end
  endtask

  task automatic unexpected(input string name, input int chan, input logic [IO_B-1:0] data);
    checks++;
    errors++;
    $display("FAIL %s at cyc %0d: unexpected event chan=%0d data=%h, expected none", name, cyc, chan, data);
  endtask

  task automatic missing(input string name, input exp_t e);
    checks++;
    errors++;
    $display("FAIL %s at cyc %0d: no event seen, expected cyc=%0d chan=%0d data=%h",
             name, cyc, e.cyc, e.chan, e.data);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i]  = 1'b0;
      m_pdata[i] = '0;
    end
    m_last      = NCH - 1;
    m_g         = 0;
    m_issue_cyc = 0;
    m_issuing   = 1'b0;
    m_waiting   = 1'b0;
    exp_issue_q.delete();
    exp_out_q.delete();
    exp_ovr_q.delete();
  endtask

  // Core model: answers each issue after a random latency. It may also
  // strobe spuriously while no answer is due.
  initial begin
    int cd;
    cd = 0;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      core_out_valid = 1'b0;
      if (!reset_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            core_out_valid = 1'b1;
            core_out_data  = IO_B'($urandom);
          end
        end else if (spur_tok != 0) begin
          spur_tok       = 0;
          core_out_valid = 1'b1;
          core_out_data  = IO_B'($urandom);
        end else if (spur_en && $urandom_range(0, 15) == 0) begin
          core_out_valid = 1'b1;
          core_out_data  = IO_B'($urandom);
        end
        if (core_in_valid && !no_resp) cd = $urandom_range(lat_min, lat_max);
      end
    end
  end

  // Monitor plus reference model, evaluated on the falling edge, one step per clock cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_wdog;
    int   new_g;
    int   idx;
    bit   was_idle;
    bit   was_issuing;
    if (!reset_n) begin
      checks++;
      if ({ch_overrun, core_in_data, core_in_valid, core_chan, out_data, out_chan,
           out_valid, busy, wdog_err} != '0) begin
        errors++;
        $display("FAIL reset_outputs at cyc %0d: got ovr=%b in=%h/%b chan=%0d out=%h/%0d/%b busy=%b wdog=%b, expected all 0",
                 cyc, ch_overrun, core_in_data, core_in_valid, core_chan, out_data, out_chan,
                 out_valid, busy, wdog_err);
      end
      model_reset();
    end else begin
      // Entries whose cycle has already passed were never produced by the DUT.
      while (exp_issue_q.size() > 0 && int'(exp_issue_q[0].cyc) < cyc) missing("issue", exp_issue_q.pop_front());
      while (exp_out_q.size() > 0 && int'(exp_out_q[0].cyc) < cyc) missing("out", exp_out_q.pop_front());
      while (exp_ovr_q.size() > 0 && int'(exp_ovr_q[0].cyc) < cyc) missing("overrun", exp_ovr_q.pop_front());

      if (core_in_valid) begin
        if (exp_issue_q.size() == 0) unexpected("issue", int'(core_chan), core_in_data);
        else begin
          e = exp_issue_q.pop_front();
          cmp_exp("issue", e, int'(core_chan), core_in_data);
        end
      end
      if (out_valid) begin
        if (exp_out_q.size() == 0) unexpected("out", int'(out_chan), out_data);
        else begin
          e = exp_out_q.pop_front();
          cmp_exp("out", e, int'(out_chan), out_data);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_overrun[i]) begin
          if (exp_ovr_q.size() == 0) unexpected("overrun", i, '0);
          else begin
            e = exp_ovr_q.pop_front();
            cmp_exp("overrun", e, i, '0);
          end
        end
      end

      checks++;
      if (busy != (m_issuing || m_waiting)) begin
        errors++;
        $display("FAIL busy at cyc %0d: got %b, expected %b", cyc, busy, m_issuing || m_waiting);
      end
      if (m_waiting) begin
        checks++;
        if (int'(core_chan) != m_g) begin
          errors++;
          $display("FAIL core_chan_hold at cyc %0d: got %0d, expected %0d", cyc, core_chan, m_g);
        end
      end

      exp_wdog = 1'b0;
`ifdef FILT_SCHED_WDOG_EN
      exp_wdog = m_waiting && !core_out_valid && (cyc - m_issue_cyc == WDOG_CYC);
`endif
      checks++;
      if (wdog_err != exp_wdog) begin
        errors++;
        $display("FAIL wdog_err at cyc %0d: got %b, expected %b", cyc, wdog_err, exp_wdog);
      end

      // Advance the model by one cycle using this cycle's inputs.
      was_idle    = !m_issuing && !m_waiting;
      was_issuing = m_issuing;
      new_g       = -1;
      if (was_idle) begin
        for (int k = 1; k <= NCH; k++) begin
          idx = (m_last + k) % NCH;
          if (new_g < 0 && m_pend[idx]) new_g = idx;
        end
      end
      if (m_waiting) begin
        if (core_out_valid) begin
          exp_out_q.push_back(mk(cyc + 1, m_g, core_out_data));
          m_last    = m_g;
          m_waiting = 1'b0;
        end else if (exp_wdog) begin
          m_last    = m_g;
          m_waiting = 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i]) begin
          if (m_pend[i] && !(was_issuing && m_g == i)) exp_ovr_q.push_back(mk(cyc + 1, i, '0));
          m_pend[i]  = 1'b1;
          m_pdata[i] = ch_data[i*IO_B +: IO_B];
        end
      end
      if (was_issuing) begin
        if (!ch_valid[m_g]) m_pend[m_g] = 1'b0;
        m_issuing = 1'b0;
        m_waiting = 1'b1;
      end
      if (new_g >= 0) begin
        m_g         = new_g;
        m_issuing   = 1'b1;
        m_issue_cyc = cyc + 1;
        exp_issue_q.push_back(mk(cyc + 1, new_g, m_pdata[new_g]));
      end
    end

    if (end_req && !end_done) begin
      while (exp_issue_q.size() > 0) missing("issue_end", exp_issue_q.pop_front());
      while (exp_out_q.size() > 0) missing("out_end", exp_out_q.pop_front());
      while (exp_ovr_q.size() > 0) missing("overrun_end", exp_ovr_q.pop_front());
      end_done = 1'b1;
    end
    cyc++;
  end

  task automatic drive(input logic [NCH-1:0] mask, input logic [NCH*IO_B-1:0] data);
    @(posedge clk);
    #1;
    ch_valid = mask;
    ch_data  = data;
  endtask

  task automatic quiet(input int n);
    repeat (n) drive('0, rand_data());
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
  endtask

  // Main sequence
  initial begin
    logic [NCH*IO_B-1:0] d;
    logic [NCH-1:0]      mask;
    ch_valid = '0;
    ch_data  = '0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single sample on channel 2
    set_lat(5, 5);
    d = rand_data();
    d[2*IO_B +: IO_B] = 16'h1234;
    drive(4'b0100, d);
    quiet(20);

    // All channels at once, fixed core latency 10
    set_lat(10, 10);
    drive(4'b1111, rand_data());
    quiet(60);

    // Overwrite of a pending channel 1 sample while channel 0 is in WAIT
    set_lat(20, 20);
    drive(4'b0001, rand_data());
    quiet(3);
    d = rand_data();
    d[1*IO_B +: IO_B] = 16'h5555;
    drive(4'b0010, d);
    quiet(2);
    d[1*IO_B +: IO_B] = 16'h6666;
    drive(4'b0010, d);
    quiet(50);

    // Capture on channel 0 in its own ISSUE cycle
    set_lat(6, 6);
    drive(4'b0001, rand_data());
    quiet(1);
    drive(4'b0001, rand_data());
    quiet(30);

    // Reset during WAIT, then a late core strobe that must be ignored
    set_lat(30, 30);
    drive(4'b0001, rand_data());
    quiet(8);
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    spur_tok = 1;
    quiet(10);

`ifdef FILT_SCHED_WDOG_EN
    // Core never answers, so the watchdog drops each sample in turn
    no_resp = 1'b1;
    drive(4'b0011, rand_data());
    quiet(160);
    no_resp = 1'b0;
    quiet(5);
`endif

    // Random traffic with random latency and spurious core strobes
    set_lat(1, 12);
    spur_en = 1'b1;
    repeat (800) begin
      mask = '0;
      for (int i = 0; i < NCH; i++) mask[i] = ($urandom_range(0, 3) == 0);
      drive(mask, rand_data());
    end
    spur_en = 1'b0;
    quiet(60);

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
